// File: rtl/rom_loader_pkg.sv
// Shared constants and FSM encoding for the serial ROM loader.
// ST_CHK exists only when ROM_LOADER_CHECKSUM_EN is defined.
package rom_loader_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_H  = 3'd1;
  localparam logic [2:0] ST_LEN_L  = 3'd2;
  localparam logic [2:0] ST_DATA_H = 3'd3;
  localparam logic [2:0] ST_DATA_L = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHK    = 3'd7;
`endif

  // A session may load between one word and a completely full memory.
  function automatic logic length_ok(input logic [15:0] len, input int rom_bits);
    return (len != 16'd0) && ({16'd0, len} <= (32'd1 << rom_bits));
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-link and instruction-memory write bus of the ROM loader.
// The loader sits on the slave modport; the byte source uses master.
interface rom_loader_if import rom_loader_pkg::*; #(
  parameter int MSB_DATA = 16,
  parameter int MSB_ROM  = 11,
  parameter int LSB      = 0
) ();

  logic [BYTE_W-1:0]             BYTE_i;
  logic                          BYTE_VALID_i;
  logic                          BYTE_READY_o;
  logic                          WR_im_o;
  logic [LSB+MSB_ROM-1:LSB]      ADDR_im_o;
  logic [LSB+MSB_DATA-1:LSB]     DATA_im_o;

  modport master (
    output BYTE_i, BYTE_VALID_i,
    input  BYTE_READY_o, WR_im_o, ADDR_im_o, DATA_im_o
  );

  modport slave (
    input  BYTE_i, BYTE_VALID_i,
    output BYTE_READY_o, WR_im_o, ADDR_im_o, DATA_im_o
  );

endinterface

// File: rtl/rom_loader_assembler.sv
// Joins a high/low byte pair into one instruction word and issues a
// registered single-cycle write strobe with the word's address.
module rom_loader_assembler import rom_loader_pkg::*; #(
  parameter int MSB_DATA = 16,
  parameter int MSB_ROM  = 11,
  parameter int LSB      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hi_load,
  input  logic                      lo_load,
  input  logic [BYTE_W-1:0]         byte_in,
  input  logic [MSB_ROM-1:0]        word_index,
  output logic                      wr_strobe,
  output logic [LSB+MSB_ROM-1:LSB]  wr_addr,
  output logic [LSB+MSB_DATA-1:LSB] wr_data
);

  logic [BYTE_W-1:0] high_byte;

  // Address and data hold their last written value between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_byte <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= lo_load;
      if (hi_load) begin
        high_byte <= byte_in;
      end
      if (lo_load) begin
        wr_addr <= word_index;
        wr_data <= MSB_DATA'({high_byte, byte_in});
      end
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Loads a length-prefixed big-endian word stream into instruction memory
// and releases the CPU afterwards. ROM_LOADER_CHECKSUM_EN adds an XOR check byte.
module rom_loader import rom_loader_pkg::*; #(
  parameter int MSB_DATA = 16,
  parameter int MSB_ROM  = 11,
  parameter int LSB      = 0
) (
  input  logic         CLOCK_i,
  input  logic         RESET_i,
  input  logic         START_i,
  rom_loader_if.slave  link,
  output logic         CPU_RUN_o,
  output logic         BUSY_o,
  output logic         ERROR_o
);

  logic [2:0]          state;
  logic [BYTE_W-1:0]   len_high;
  logic [15:0]         len_word;
  logic [MSB_ROM-1:0]  word_index;
  logic [MSB_ROM-1:0]  last_index;
  logic                accept;
  logic                last_word;
  logic                hi_load;
  logic                lo_load;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   chk_acc;
`endif

`ifdef ROM_LOADER_CHECKSUM_EN
  assign link.BYTE_READY_o = (state == ST_LEN_H) || (state == ST_LEN_L) ||
                             (state == ST_DATA_H) || (state == ST_DATA_L) ||
                             (state == ST_CHK);
`else
  assign link.BYTE_READY_o = (state == ST_LEN_H) || (state == ST_LEN_L) ||
                             (state == ST_DATA_H) || (state == ST_DATA_L);
`endif

  assign accept    = link.BYTE_VALID_i && link.BYTE_READY_o;
  assign len_word  = {len_high, link.BYTE_i};
  assign last_word = (word_index == last_index);
  assign hi_load   = accept && (state == ST_DATA_H);
  assign lo_load   = accept && (state == ST_DATA_L);

  // The run enable drops combinationally so a restart halts the CPU at once.
  assign CPU_RUN_o = (state == ST_DONE) && !START_i;
  assign BUSY_o    = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

  // The index stops at the last word, so a full load never wraps the address.
  always_ff @(posedge CLOCK_i or negedge RESET_i) begin
    if (!RESET_i) begin
      state      <= ST_IDLE;
      len_high   <= '0;
      word_index <= '0;
      last_index <= '0;
      ERROR_o    <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      chk_acc    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (START_i) begin
            state      <= ST_LEN_H;
            word_index <= '0;
            ERROR_o    <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            chk_acc    <= '0;
`endif
          end
        end
        ST_LEN_H: begin
          if (accept) begin
            len_high <= link.BYTE_i;
            state    <= ST_LEN_L;
          end
        end
        ST_LEN_L: begin
          if (accept) begin
            if (length_ok(len_word, MSB_ROM)) begin
              last_index <= MSB_ROM'(len_word - 16'd1);
              state      <= ST_DATA_H;
            end else begin
              state   <= ST_ERROR;
              ERROR_o <= 1'b1;
            end
          end
        end
        ST_DATA_H: begin
          if (accept) begin
            state <= ST_DATA_L;
`ifdef ROM_LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ link.BYTE_i;
`endif
          end
        end
        ST_DATA_L: begin
          if (accept) begin
`ifdef ROM_LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ link.BYTE_i;
`endif
            if (last_word) begin
`ifdef ROM_LOADER_CHECKSUM_EN
              state <= ST_CHK;
`else
              state <= ST_DONE;
`endif
            end else begin
              word_index <= word_index + MSB_ROM'(1);
              state      <= ST_DATA_H;
            end
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (accept) begin
            if (link.BYTE_i == chk_acc) begin
              state <= ST_DONE;
            end else begin
              state   <= ST_ERROR;
              ERROR_o <= 1'b1;
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  rom_loader_assembler #(
    .MSB_DATA (MSB_DATA),
    .MSB_ROM  (MSB_ROM),
    .LSB      (LSB)
  ) u_assembler (
    .clk        (CLOCK_i),
    .rst_n      (RESET_i),
    .hi_load    (hi_load),
    .lo_load    (lo_load),
    .byte_in    (link.BYTE_i),
    .word_index (word_index),
    .wr_strobe  (link.WR_im_o),
    .wr_addr    (link.ADDR_im_o),
    .wr_data    (link.DATA_im_o)
  );

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter MSB_DATA, default 16, instruction word width.
REQ-002 Parameter MSB_ROM, default 11, instruction-memory address width.
REQ-003 Parameter LSB, default 0, low bit index of all buses.
REQ-004 CLOCK_i  input  1  single system clock; all state changes on its rising edge.
REQ-005 RESET_i  input  1  reset, asynchronous, active-low.
REQ-006 START_i  input  1  begins a load session; one-cycle pulse.
REQ-007 BYTE_i  input  8  serial-link byte.
REQ-008 BYTE_VALID_i  input  1  BYTE_i holds a valid byte.
REQ-009 BYTE_READY_o  output  1  loader accepts a byte; transfer occurs when VALID and READY are both high on a clock edge.
REQ-010 WR_im_o  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 ADDR_im_o  output  MSB_ROM  instruction-memory write address.
REQ-012 DATA_im_o  output  MSB_DATA  instruction-memory write data.
REQ-013 CPU_RUN_o  output  1  high releases the processor; low holds it stopped.
REQ-014 BUSY_o  output  1  load session in progress.
REQ-015 ERROR_o  output  1  last session failed; held until next START_i.

Function
REQ-016 States: ST_IDLE, ST_LEN_H, ST_LEN_L, ST_DATA_H, ST_DATA_L, ST_CHK (macro only), ST_DONE, ST_ERROR.
REQ-017 ST_IDLE, ST_DONE, ST_ERROR: START_i -> ST_LEN_H, clear word counter, address and ERROR_o; START_i in any other state is ignored.
REQ-018 ST_LEN_H/ST_LEN_L: two accepted bytes form word count N, big-endian; only bits [MSB_ROM:0] of the 16-bit value are legal.
REQ-019 N = 0 or N > 2^MSB_ROM -> ST_ERROR on the edge accepting the low length byte.
REQ-020 ST_DATA_H accepts high byte, ST_DATA_L accepts low byte; on the edge accepting the low byte, WR_im_o pulses high for exactly one cycle with DATA_im_o = {high, low} and ADDR_im_o = current word index.
REQ-021 Write latency: WR_im_o registered, asserted in the cycle following the low-byte acceptance edge.
REQ-022 Word index starts at 0, increments by 1 after each write; after word N-1 go to ST_DONE (or ST_CHK with macro).
REQ-023 BYTE_READY_o high only in ST_LEN_H, ST_LEN_L, ST_DATA_H, ST_DATA_L, ST_CHK; VALID without READY consumes nothing.
REQ-024 BYTE_VALID_i low stalls the FSM indefinitely with no side effects.
REQ-025 CPU_RUN_o high only in ST_DONE; it drops in the same cycle START_i is sampled in ST_DONE.
REQ-026 BUSY_o high in every state except ST_IDLE, ST_DONE, ST_ERROR.
REQ-027 ERROR_o set on entry to ST_ERROR, cleared only by START_i or reset.
REQ-028 N = 2^MSB_ROM fills memory exactly; address never wraps past 2^MSB_ROM-1.

Reset
REQ-029 RESET_i low asynchronously forces ST_IDLE, counters 0, and all outputs 0 (WR_im_o, ADDR_im_o, DATA_im_o, BYTE_READY_o, CPU_RUN_o, BUSY_o, ERROR_o).
REQ-030 Reset mid-session abandons the load; already-written words are not rolled back; the processor stays stopped until a full successful session.

Configuration
REQ-031 Macro ROM_LOADER_CHECKSUM_EN defined: after the last data byte, one byte is accepted in ST_CHK; it must equal the XOR of all 2N data bytes, giving ST_DONE, otherwise ST_ERROR.
REQ-032 Macro undefined: ST_CHK and the XOR accumulator do not exist; last data byte -> ST_DONE.

Structure
REQ-033 Shared package rom_loader_pkg holds the state enumeration and the byte width constant (8).
REQ-034 One sub-module, rom_loader_assembler: byte-pair to word register with write-strobe generation; FSM stays in rom_loader.

Verification
REQ-035 Reset, START_i, bytes 00 02 12 34 AB CD -> writes (0,0x1234), (1,0xABCD); CPU_RUN_o=1, BUSY_o=0.
REQ-036 Length bytes 00 00 -> ST_ERROR, ERROR_o=1, no WR_im_o pulse, CPU_RUN_o=0.
REQ-037 Length 08 01 (2049) -> ERROR_o=1; then START_i with a valid stream -> ERROR_o=0, clean load.
REQ-038 Random BYTE_VALID_i gaps on the REQ-035 stream -> identical write sequence, one WR_im_o pulse per word.
REQ-039 RESET_i low after first data byte -> all outputs 0 immediately; a following full session loads correctly.
REQ-040 Macro on: stream 00 01 12 34 26 -> CPU_RUN_o=1; checksum 27 -> ERROR_o=1, CPU_RUN_o=0.
